// File: rtl/bin_to_bcd_4dig_if.sv
// Start/result handshake between a binary source and the BCD converter.
// The converter sits on the slave side; the requester drives bin/start.
interface bin_to_bcd_4dig_if;
    logic [13:0] bin;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    modport master (output bin, start, input busy, done, bcd, overflow);
    modport slave  (input bin, start, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_4dig.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble,
// one bit per clock). The result register only moves on completion.
module bin_to_bcd_4dig #(
    parameter bit CLAMP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    bin_to_bcd_4dig_if.slave   bus
);
    localparam int NUM_DIG = 4;
    localparam int DIG_W   = 4;
    localparam int BIN_W   = 14;
    localparam int BCD_W   = NUM_DIG * DIG_W;
    localparam logic [3:0]       LAST_ITER = 4'd13;
    localparam logic [BIN_W-1:0] MAX_DEC   = 14'd9999;
    localparam logic [BCD_W-1:0] OVF_PAT   = CLAMP ? 16'h9999 : 16'hEEEE;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sreg_q, sreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    // Add-3 correction per nibble, no carry between digits.
    logic [NUM_DIG-1:0][DIG_W-1:0] nib_adj;
    logic [BCD_W-1:0]              adj_flat;

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
        assign nib_adj[g] = (scratch_q[g*DIG_W +: DIG_W] >= 4'd5)
                          ? scratch_q[g*DIG_W +: DIG_W] + 4'd3
                          : scratch_q[g*DIG_W +: DIG_W];
    end
    assign adj_flat = nib_adj;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d     = bus.bin;
                    scratch_d  = '0;
                    pend_ovf_d = (bus.bin > MAX_DEC);
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj_flat[BCD_W-2:0], sreg_q[BIN_W-1]};
                sreg_d    = {sreg_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) state_d = LOAD;
            end
            LOAD: begin
                bcd_d   = pend_ovf_q ? OVF_PAT : scratch_q;
                ovf_d   = pend_ovf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered from the next state so busy/done never overlap.
        busy_d = (state_d != IDLE);
        done_d = (state_q == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule
